// File: rtl/switch_reader_pkg.sv
// rtl/switch_reader_pkg.sv - shared IO constants for the switch/key input port
// Status-word layout, switch width and default debounce settings.
package switch_reader_pkg;

   localparam int SW_WIDTH                = 16;
   localparam int KEY_FLAG_BIT            = 0;
   localparam int PRESS_CNT_LSB           = 8;
   localparam int PRESS_CNT_W             = 8;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEFAULT_CNT_W           = 20;

   typedef logic [PRESS_CNT_W-1:0] press_cnt_t;
   typedef logic [SW_WIDTH-1:0]    sw_word_t;

   function automatic logic [31:0] status_word(input press_cnt_t cnt, input logic flag);
      logic [31:0] w;
      w                               = '0;
      w[PRESS_CNT_LSB +: PRESS_CNT_W] = cnt;
      w[KEY_FLAG_BIT]                 = flag;
      return w;
   endfunction

endpackage

// File: rtl/switch_reader_input_debounce.sv
// rtl/switch_reader_input_debounce.sv - two-flop synchronizer plus word debouncer
// Debouncer present only when SWITCH_DEBOUNCE_EN is defined; otherwise stable = sync2.
module input_debounce #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef SWITCH_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Whole word is one candidate: any bit change restarts the stability count.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = cand_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
`else
   // Counter parameters only matter to the debouncer; checked here so both builds elaborate alike.
   if (DEBOUNCE_CYCLES >= 1 && CNT_W >= 1) begin : g_pass
      assign stable = sync2_q;
   end else begin : g_pass_cfg
      assign stable = sync2_q;
   end
`endif

endmodule

// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - CPU-readable switch bank and confirm-key port
// Build macro SWITCH_DEBOUNCE_EN enables the input debouncers.
module switch_reader
   import switch_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                SwitchCtrl,
   input  logic                addr_sel,
   input  logic [SW_WIDTH-1:0] switch_raw,
   input  logic                key_raw,
   output logic [31:0]         read_data
);

   sw_word_t   switch_stable;
   logic       key_stable;
   logic       press;
   logic       key_d_q, key_d_d;
   logic       key_flag_q, key_flag_d;
   press_cnt_t press_cnt_q, press_cnt_d;

   input_debounce #(
      .WIDTH          (SW_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_sw_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (switch_raw),
      .stable(switch_stable)
   );

   input_debounce #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_key_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_raw),
      .stable(key_stable)
   );

   assign press = key_stable & ~key_d_q;

   // Clear-on-read is applied first so a press on the same edge overrides it.
   always_comb begin
      key_d_d     = key_stable;
      key_flag_d  = key_flag_q;
      press_cnt_d = press_cnt_q;
      if (SwitchCtrl && addr_sel) begin
         key_flag_d = 1'b0;
      end
      if (press) begin
         key_flag_d  = 1'b1;
         press_cnt_d = press_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_d_q     <= 1'b0;
         key_flag_q  <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         key_d_q     <= key_d_d;
         key_flag_q  <= key_flag_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   always_comb begin
      read_data = '0;
      if (!rst && SwitchCtrl) begin
         if (addr_sel) begin
            read_data = status_word(press_cnt_q, key_flag_q);
         end else begin
            read_data = {{(32-SW_WIDTH){1'b0}}, switch_stable};
         end
      end
   end

endmodule

// File: tb/tb_switch_reader.sv
// tb/tb_switch_reader.sv - scoreboard bench for switch_reader with DEBOUNCE_CYCLES=4
// Expected read words are queued by the stimulus and checked by a negedge monitor.
module tb_switch_reader;

   localparam int DEB = 4;
`ifdef SWITCH_DEBOUNCE_EN
   localparam int LAT_S = DEB + 2;
   localparam bit DEB_ON = 1'b1;
`else
   localparam int LAT_S = 1;
   localparam bit DEB_ON = 1'b0;
`endif
   localparam int LAT_K = LAT_S + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        SwitchCtrl;
   logic        addr_sel;
   logic [15:0] switch_raw;
   logic        key_raw;
   logic [31:0] read_data;

   logic [31:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_rd  = 0;

   switch_reader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .SwitchCtrl(SwitchCtrl),
      .addr_sel  (addr_sel),
      .switch_raw(switch_raw),
      .key_raw   (key_raw),
      .read_data (read_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [31:0] e;
      if (SwitchCtrl) begin
         n_cmp++;
         n_rd++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL read%0d no expected entry, got %h", n_rd, read_data);
         end else begin
            e = exp_q.pop_front();
            if (read_data !== e) begin
               n_bad++;
               $display("FAIL read%0d addr_sel=%0b got %h want %h", n_rd, addr_sel, read_data, e);
            end
         end
      end else begin
         n_cmp++;
         if (read_data !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_zero at %0t got %h want 00000000", $time, read_data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   task automatic cyc(input logic sc, input logic as, input logic [31:0] exp);
      @(posedge clk);
      #1;
      SwitchCtrl = sc;
      addr_sel   = as;
      if (sc) exp_q.push_back(exp);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      SwitchCtrl = 1'b0;
      addr_sel   = 1'b0;
      switch_raw = 16'hFFFF;
      key_raw    = 1'b1;

      // Reset held over two edges; reads return zero.
      cyc(1'b1, 1'b1, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      rst = 1'b0;

      // Inputs held through reset commit after release; key counts as one press.
      for (int i = 0; i < LAT_S; i++) cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000FFFF);
      cyc(1'b1, 1'b1, 32'h00000101);
      cyc(1'b1, 1'b1, 32'h00000100);

      // Release everything and let it settle; release is not a press.
      switch_raw = 16'h0000;
      key_raw    = 1'b0;
      for (int i = 0; i < LAT_S; i++) cyc(1'b1, 1'b0, 32'h0000FFFF);
      cyc(1'b1, 1'b0, 32'h0);
      idle(3);
      cyc(1'b1, 1'b1, 32'h00000100);

      // Switch commit.
      switch_raw = 16'hA5C3;
      for (int i = 0; i < LAT_S; i++) cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000A5C3);
      cyc(1'b1, 1'b0, 32'h0000A5C3);
      switch_raw = 16'h0000;
      idle(LAT_S + 2);
      cyc(1'b1, 1'b0, 32'h0);

      // Three-cycle glitch: filtered with debounce, passed straight through without.
      switch_raw = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         if (!DEB_ON && i >= 1 && i <= 3) cyc(1'b1, 1'b0, 32'h1);
         else                             cyc(1'b1, 1'b0, 32'h0);
         if (i == 2) switch_raw = 16'h0000;
      end

      // Second press, then clear on read.
      key_raw = 1'b1;
      for (int i = 0; i < LAT_K; i++) cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h00000201);
      cyc(1'b1, 1'b1, 32'h00000200);
      key_raw = 1'b0;
      idle(LAT_S + 3);

      // Status read on the very edge of the third press: set wins.
      key_raw = 1'b1;
      idle(LAT_K - 1);
      cyc(1'b1, 1'b1, 32'h00000200);
      cyc(1'b1, 1'b1, 32'h00000301);
      cyc(1'b1, 1'b1, 32'h00000300);
      key_raw = 1'b0;
      idle(LAT_S + 3);

      // Presses 4..255, then the 256th wraps the counter.
      for (int p = 4; p <= 255; p++) begin
         key_raw = 1'b1;
         idle(LAT_K + 2);
         key_raw = 1'b0;
         idle(LAT_S + 3);
      end
      cyc(1'b1, 1'b1, 32'h0000FF01);
      cyc(1'b1, 1'b1, 32'h0000FF00);
      key_raw = 1'b1;
      idle(LAT_K);
      cyc(1'b1, 1'b1, 32'h00000001);
      cyc(1'b1, 1'b1, 32'h00000000);
      idle(3);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_reader.md
# switch_reader

Memory-mapped input peripheral for the switch bank and confirm button; the read-side counterpart of the LED output port on the CPU's IO bus. Synchronizes and debounces 16 switches and one push button, latches a sticky "key pressed" flag with a press counter, and returns either the switch value or a status word on CPU reads selected by the address decoder. The status flag clears on read, giving software a polled handshake for "input ready".

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before committing a new input value (10 ms at 100 MHz); minimum 1
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- SwitchCtrl  input  1  read select from address decoder, IO read cycle active
- addr_sel  input  1  0 = switch data register, 1 = status register
- switch_raw  input  16  asynchronous switch pins
- key_raw  input  1  asynchronous confirm button, active-high
- read_data  output  32  combinational read data to CPU

## Operation
- Each input path: two-flop synchronizer (sync1, sync2), then debouncer: cand register, cnt counter, stable register.
- Debouncer per edge: if sync2 != cand, then cand <= sync2 and cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, stable <= cand and cnt holds; else cnt <= cnt+1.
- Switch vector debounced as one 16-bit word: any bit change restarts the count.
- key_d <= key_stable each edge; press = key_stable & ~key_d.
- On press: key_flag <= 1, press_cnt <= press_cnt+1 (8-bit, wraps 255 -> 0).
- Clear-on-read: at an edge with SwitchCtrl=1 and addr_sel=1, key_flag <= 0.
- Simultaneous press and clear at the same edge: set wins; key_flag stays 1 and press_cnt increments.
- read_data: rst=1 -> 0; SwitchCtrl=0 -> 0; addr_sel=0 -> {16'b0, switch_stable}; addr_sel=1 -> {16'b0, press_cnt, 7'b0, key_flag}.
- Reset (including mid-debounce): sync1, sync2, cand, cnt, stable, key_d, key_flag, press_cnt all 0. A button held through reset release registers as one press once debounced.

## Timing
- Input change first sampled at edge 0: with debounce, stable updates at edge D+2 (D = DEBOUNCE_CYCLES), given raw held constant from edge 0.
- A glitch shorter than D cycles after synchronization never reaches stable.
- key_flag and press_cnt update at edge D+3 after the button rises.
- read_data is combinational from registers; zero-cycle read latency, valid within the CPU's single read cycle.
- key_flag clears at the edge ending the status read; the read in that cycle returns key_flag=1.

## Configuration
- SWITCH_DEBOUNCE_EN defined: debouncers instantiated as above.
- Not defined: stable = sync2 directly, with no cand/cnt. Stable updates at edge 1; DEBOUNCE_CYCLES and CNT_W are unused. All other behaviour is unchanged.

## Structure
- Shared IO package: status-word bit positions (KEY_FLAG_BIT = 0, PRESS_CNT_LSB = 8), switch width constant 16, and the default debounce count.
- One sub-module, input_debounce: parameters WIDTH, DEBOUNCE_CYCLES, CNT_W. Contains synchronizer plus debouncer, honours SWITCH_DEBOUNCE_EN, and is instantiated twice (WIDTH=16 for switches, WIDTH=1 for the key).

## Test plan
- Use DEBOUNCE_CYCLES=4 for all scenarios.
- Reset: assert rst for 2 cycles with switch_raw=16'hFFFF and key_raw=1. read_data=0 during reset; after release, every register is 0 until debounce completes.
- Switch commit: switch_raw=16'hA5C3 at edge 0, SwitchCtrl=1, addr_sel=0. read_data=32'h0 through edge 5 and 32'h0000A5C3 after edge 6.
- Glitch rejection: switch_raw pulses 16'h0001 for 3 cycles, then returns to 0. read_data stays 0.
- Press and clear: key_raw held high. Status reads 32'h00000101 after edge 7. A status read at the next edge returns 32'h101, after which status reads 32'h100.
- Simultaneous set/clear: issue a status read on the exact edge of a second press. key_flag remains 1 and press_cnt=2. A 256th press wraps press_cnt to 0.
